branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage RV32 pipeline. Sits beside the fetch stage: it answers a combinational lookup for the current fetch PC (prediction bit and target that travel down the pipeline as `bpr`), and accepts a resolution record from the execute stage, which trains the table and reports whether the in-flight prediction was wrong. It holds a direct-mapped table of 2-bit saturating counters with tags and targets, plus a saturating mispredict counter for performance measurement.

---
 rtl/branch_predictor.sv | 112 +++++++++++
 tb/tb_branch_predictor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with tags and targets.
// Combinational fetch lookup, one-cycle training from EX, saturating mispredict counter.
module branch_predictor #(
   parameter int IDX_BITS = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [11:0] pc_i,
   output logic        hit_o,
   output logic        bpr_o,
   output logic [11:0] target_o,
   input  logic        upd_valid_i,
   input  logic [11:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [11:0] upd_target_i,
   input  logic        upd_bpr_i,
   input  logic [11:0] upd_ptarget_i,
   output logic        mispredict_o,
   output logic [11:0] redirect_pc_o,
   output logic [15:0] mispred_cnt_o
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = 12 - IDX_BITS - 2;

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [1:0]        r_ctr    [ENTRIES];
   logic [11:0]       r_target [ENTRIES];
   logic [15:0]       r_mp_cnt;

   logic [IDX_BITS-1:0] w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [IDX_BITS-1:0] w_uidx;
   logic [TAG_W-1:0]    w_utag;
   logic                w_u_hit;
   logic [1:0]          w_ctr_cur;
   logic [1:0]          w_ctr_nxt;
   logic                w_mispredict;

   assign w_idx  = pc_i[IDX_BITS+1:2];
   assign w_tag  = pc_i[11:IDX_BITS+2];
   assign w_uidx = upd_pc_i[IDX_BITS+1:2];
   assign w_utag = upd_pc_i[11:IDX_BITS+2];

   // Fetch-side lookup sees only registered contents, so no same-cycle bypass.
   assign hit_o    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign bpr_o    = hit_o && r_ctr[w_idx][1];
   assign target_o = bpr_o ? r_target[w_idx] : (pc_i + 12'd4);

   assign w_mispredict  = upd_valid_i &&
                          ((upd_taken_i != upd_bpr_i) ||
                           (upd_taken_i && upd_bpr_i && (upd_target_i != upd_ptarget_i)));
   assign mispredict_o  = w_mispredict;
   assign redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + 12'd4);
   assign mispred_cnt_o = r_mp_cnt;

   assign w_u_hit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
   assign w_ctr_cur = r_ctr[w_uidx];

   // Saturating counter step for the entry being trained.
   always_comb begin
      w_ctr_nxt = w_ctr_cur;
      if (upd_taken_i) begin
         if (w_ctr_cur != 2'b11) begin
            w_ctr_nxt = w_ctr_cur + 2'd1;
         end else begin
            w_ctr_nxt = w_ctr_cur;
         end
      end else begin
         if (w_ctr_cur != 2'b00) begin
            w_ctr_nxt = w_ctr_cur - 2'd1;
         end else begin
            w_ctr_nxt = w_ctr_cur;
         end
      end
   end

   // Table training; only taken branches allocate on a miss.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_ctr[i]    <= 2'b01;
            r_target[i] <= 12'h000;
         end
      end else if (upd_valid_i) begin
         if (w_u_hit) begin
            r_ctr[w_uidx] <= w_ctr_nxt;
            if (upd_taken_i) begin
               r_target[w_uidx] <= upd_target_i;
            end
         end else if (upd_taken_i) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_ctr[w_uidx]    <= 2'b10;
            r_target[w_uidx] <= upd_target_i;
         end
      end
   end

   // Performance counter, sticks at all-ones.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_mp_cnt <= 16'h0000;
      end else if (w_mispredict && (r_mp_cnt != 16'hFFFF)) begin
         r_mp_cnt <= r_mp_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_BITS=4).
module tb_branch_predictor;

   logic        CLK;
   logic        RSTn;
   logic [11:0] pc_i;
   logic        hit_o;
   logic        bpr_o;
   logic [11:0] target_o;
   logic        upd_valid_i;
   logic [11:0] upd_pc_i;
   logic        upd_taken_i;
   logic [11:0] upd_target_i;
   logic        upd_bpr_i;
   logic [11:0] upd_ptarget_i;
   logic        mispredict_o;
   logic [11:0] redirect_pc_o;
   logic [15:0] mispred_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   branch_predictor #(.IDX_BITS(4)) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .pc_i          (pc_i),
      .hit_o         (hit_o),
      .bpr_o         (bpr_o),
      .target_o      (target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .upd_bpr_i     (upd_bpr_i),
      .upd_ptarget_i (upd_ptarget_i),
      .mispredict_o  (mispredict_o),
      .redirect_pc_o (redirect_pc_o),
      .mispred_cnt_o (mispred_cnt_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic upd(input logic [11:0] pc, input logic tk, input logic [11:0] tgt,
                      input logic bp, input logic [11:0] ptgt);
      upd_valid_i   = 1'b1;
      upd_pc_i      = pc;
      upd_taken_i   = tk;
      upd_target_i  = tgt;
      upd_bpr_i     = bp;
      upd_ptarget_i = ptgt;
      #1;
   endtask

   task automatic idle();
      upd_valid_i = 1'b0;
      #1;
   endtask

   initial begin
      RSTn = 1'b0; pc_i = 12'h010;
      upd_valid_i = 1'b0; upd_pc_i = 12'h000; upd_taken_i = 1'b0;
      upd_target_i = 12'h000; upd_bpr_i = 1'b0; upd_ptarget_i = 12'h000;
      #2;
      chk("rst_hit", 32'(hit_o), 32'd0);
      chk("rst_bpr", 32'(bpr_o), 32'd0);
      chk("rst_tgt", 32'(target_o), 32'h014);
      chk("rst_cnt", 32'(mispred_cnt_o), 32'd0);
      chk("rst_mp", 32'(mispredict_o), 32'd0);
      chk("rst_redir", 32'(redirect_pc_o), 32'h004);
      pc_i = 12'hFFC; #1;
      chk("rst_tgt_wrap", 32'(target_o), 32'h000);
      tick();
      RSTn = 1'b1;
      pc_i = 12'h010;

      // first allocation
      upd(12'h010, 1'b1, 12'h040, 1'b0, 12'h000);
      chk("u1_mp", 32'(mispredict_o), 32'd1);
      chk("u1_redir", 32'(redirect_pc_o), 32'h040);
      chk("u1_prehit", 32'(hit_o), 32'd0);
      tick(); idle();
      chk("u1_hit", 32'(hit_o), 32'd1);
      chk("u1_bpr", 32'(bpr_o), 32'd1);
      chk("u1_tgt", 32'(target_o), 32'h040);
      chk("u1_cnt", 32'(mispred_cnt_o), 32'd1);

      // walk counter down to strong not-taken
      upd(12'h010, 1'b0, 12'h000, 1'b1, 12'h040);
      chk("u2_mp", 32'(mispredict_o), 32'd1);
      chk("u2_redir", 32'(redirect_pc_o), 32'h014);
      tick(); idle();
      chk("u2_hit", 32'(hit_o), 32'd1);
      chk("u2_bpr", 32'(bpr_o), 32'd0);
      chk("u2_tgt", 32'(target_o), 32'h014);
      chk("u2_cnt", 32'(mispred_cnt_o), 32'd2);
      upd(12'h010, 1'b0, 12'h000, 1'b0, 12'h000);
      chk("u3_mp", 32'(mispredict_o), 32'd0);
      tick();
      upd(12'h010, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(); idle();
      chk("u4_hit", 32'(hit_o), 32'd1);
      chk("u4_bpr", 32'(bpr_o), 32'd0);
      chk("u4_cnt", 32'(mispred_cnt_o), 32'd2);

      // wrong-target mispredict; counter 00 -> 01 (no wrap)
      upd(12'h010, 1'b1, 12'h080, 1'b1, 12'h040);
      chk("u5_mp", 32'(mispredict_o), 32'd1);
      chk("u5_redir", 32'(redirect_pc_o), 32'h080);
      tick(); idle();
      chk("u5_bpr", 32'(bpr_o), 32'd0);
      chk("u5_cnt", 32'(mispred_cnt_o), 32'd3);
      upd(12'h010, 1'b1, 12'h080, 1'b0, 12'h000);
      tick(); idle();
      chk("u6_bpr", 32'(bpr_o), 32'd1);
      chk("u6_tgt", 32'(target_o), 32'h080);
      chk("u6_cnt", 32'(mispred_cnt_o), 32'd4);

      // saturate at 11, then one not-taken still predicts taken
      upd(12'h010, 1'b1, 12'h080, 1'b1, 12'h080);
      chk("u7_mp", 32'(mispredict_o), 32'd0);
      tick();
      tick();
      upd(12'h010, 1'b0, 12'h000, 1'b1, 12'h080);
      tick(); idle();
      chk("u9_bpr", 32'(bpr_o), 32'd1);
      chk("u9_cnt", 32'(mispred_cnt_o), 32'd5);

      // aliasing at index 4
      pc_i = 12'h050; #1;
      chk("al_miss", 32'(hit_o), 32'd0);
      chk("al_tgt", 32'(target_o), 32'h054);
      upd(12'h050, 1'b1, 12'h100, 1'b0, 12'h000);
      tick(); idle();
      chk("al_hit", 32'(hit_o), 32'd1);
      chk("al_new_tgt", 32'(target_o), 32'h100);
      pc_i = 12'h010; #1;
      chk("al_old_gone", 32'(hit_o), 32'd0);
      chk("al_cnt", 32'(mispred_cnt_o), 32'd6);

      // not-taken miss never allocates
      upd(12'h060, 1'b0, 12'h000, 1'b0, 12'h000);
      tick(); idle();
      pc_i = 12'h060; #1;
      chk("nt_noalloc", 32'(hit_o), 32'd0);

      // same-cycle lookup and update, no bypass
      pc_i = 12'h020;
      upd(12'h020, 1'b1, 12'h0A0, 1'b0, 12'h000);
      chk("sc_prehit", 32'(hit_o), 32'd0);
      tick(); idle();
      chk("sc_hit", 32'(hit_o), 32'd1);
      chk("sc_tgt", 32'(target_o), 32'h0A0);
      chk("sc_cnt", 32'(mispred_cnt_o), 32'd7);

      // invalid update never mispredicts; redirect wraps
      upd_valid_i = 1'b0; upd_pc_i = 12'hFFC; upd_taken_i = 1'b0; upd_bpr_i = 1'b1; #1;
      chk("nv_mp", 32'(mispredict_o), 32'd0);
      chk("redir_wrap", 32'(redirect_pc_o), 32'h000);

      // async reset between edges, with an update pending
      #1;
      upd(12'h030, 1'b1, 12'h0C0, 1'b0, 12'h000);
      RSTn = 1'b0; #1;
      chk("ar_hit", 32'(hit_o), 32'd0);
      chk("ar_bpr", 32'(bpr_o), 32'd0);
      chk("ar_cnt", 32'(mispred_cnt_o), 32'd0);
      tick();
      RSTn = 1'b1; idle();
      pc_i = 12'h030; #1;
      chk("ar_noupd", 32'(hit_o), 32'd0);
      pc_i = 12'h050; #1;
      chk("ar_clear", 32'(hit_o), 32'd0);
      chk("ar_cnt2", 32'(mispred_cnt_o), 32'd0);

      // first edge after release trains
      pc_i = 12'h030;
      upd(12'h030, 1'b1, 12'h0C0, 1'b0, 12'h000);
      tick(); idle();
      chk("pr_hit", 32'(hit_o), 32'd1);
      chk("pr_cnt", 32'(mispred_cnt_o), 32'd1);

      // counter saturation
      upd(12'h100, 1'b0, 12'h000, 1'b1, 12'h000);
      repeat (65533) tick();
      chk("sat_fffe", 32'(mispred_cnt_o), 32'hFFFE);
      tick();
      chk("sat_ffff", 32'(mispred_cnt_o), 32'hFFFF);
      repeat (6) tick();
      chk("sat_hold", 32'(mispred_cnt_o), 32'hFFFF);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
